// File: rtl/kaly_round_seq.sv
// Iterative Kalyna-style encryption sequencer: shares one external round core across NR passes,
// owns the state/key registers, key whitening, per-round key mixing and the final lane add.
module kaly_round_seq #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] msg,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher,
    output logic         dp_req,
    output logic [127:0] dp_data,
    input  logic         dp_ack,
    input  logic [127:0] dp_result,
    output logic [127:0] kx_in,
    input  logic [127:0] kx_out,
    output logic         busy,
    output logic [3:0]   rnd
);

    // state   | meaning
    // IDLE    | waiting for a message/key pair
    // WHITEN  | k0 <- expand(key), st <- msg lane-add k0
    // ISSUE   | round core request held; one round per ack
    // OUT     | ciphertext offered to the sink
    typedef enum logic [1:0] {
        S_IDLE,
        S_WHITEN,
        S_ISSUE,
        S_OUT
    } state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    state_t       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] kr_q, kr_d;
    logic [127:0] cipher_q, cipher_d;
    logic [3:0]   rnd_q, rnd_d;

    // Two independent 64-bit adds; no carry crosses into the upper lane.
    function automatic logic [127:0] lane_add(input logic [127:0] a, input logic [127:0] b);
        logic [63:0] hi, lo;
        hi = a[127:64] + b[127:64];
        lo = a[63:0] + b[63:0];
        return {hi, lo};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            st_q     <= '0;
            kr_q     <= '0;
            cipher_q <= '0;
            rnd_q    <= '0;
        end else begin
            state_q  <= state_d;
            st_q     <= st_d;
            kr_q     <= kr_d;
            cipher_q <= cipher_d;
            rnd_q    <= rnd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        kr_d      = kr_q;
        cipher_d  = cipher_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dp_req    = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = msg;
                    kr_d    = key;
                    state_d = S_WHITEN;
                end
            end
            S_WHITEN: begin
                busy    = 1'b1;
                kr_d    = kx_out;
                st_d    = lane_add(st_q, kx_out);
                rnd_d   = 4'd1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                busy   = 1'b1;
                dp_req = 1'b1;
                if (dp_ack) begin
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_q == NR_L) begin
                        // kr still holds k9 here: the last round does not expand the key.
                        cipher_d = lane_add(dp_result, kr_q);
                        state_d  = S_OUT;
                    end else if (rnd_q[0]) begin
                        st_d = (kr_q << 56) ^ dp_result;
                        kr_d = kx_out;
                    end else begin
                        st_d = kx_out ^ dp_result;
                        kr_d = kx_out;
                    end
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dp_data = st_q;
    assign kx_in   = kr_q;
    assign cipher  = cipher_q;
    assign rnd     = (state_q == S_ISSUE) ? rnd_q : 4'd0;

endmodule

// File: doc/kaly_round_seq.md
# kaly_round_seq

Iterative sequencer for the 128-bit Kalyna-style encryption path. Replaces the fully unrolled ten-round chain with a single shared round core (S-box layer, shift-rows, mix-columns) that it reuses ten times. It also owns the state register, the round-key register, key whitening and the per-round key mixing. It sits between a valid/ready message source and a valid/ready ciphertext sink. It drives an external round core over a req/ack handshake and an external combinational key-expansion unit.

## Interface
- `NR`, default 10: number of round-core passes; counter width 4 bits.
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `msg`/`key` valid.
- `in_ready`, out, 1: high only in IDLE.
- `msg`, in, 128: plaintext block.
- `key`, in, 128: master key.
- `out_valid`, out, 1: `cipher` valid.
- `out_ready`, in, 1: sink accepts `cipher`.
- `cipher`, out, 128: ciphertext, registered.
- `dp_req`, out, 1: round-core request.
- `dp_data`, out, 128: round-core input, equals the state register.
- `dp_ack`, in, 1: round-core result valid this cycle.
- `dp_result`, in, 128: `MC(SR(SB(dp_data)))`.
- `kx_in`, out, 128: key-expansion input, equals the key register.
- `kx_out`, in, 128: next intermediate key, combinational from `kx_in`.
- `busy`, out, 1: high in WHITEN or ISSUE.
- `rnd`, out, 4: current round number, 0 outside ISSUE.

## Operation
- States: IDLE, WHITEN, ISSUE, OUT.
- **Lane add (⊞):** independent addition of the 64-bit halves [127:64] and [63:0], each mod 2^64. No carry crosses bit 63→64.
- **IDLE:** `in_ready`=1. On `in_valid`&`in_ready`: st←msg, kr←key, go WHITEN.
- **WHITEN (1 cycle):** kr←kx_out (k0), st←msg ⊞ kx_out, rnd←1, go ISSUE.
- **ISSUE:** `dp_req`=1; `dp_data`=st held stable until ack. On `dp_ack`, with o=dp_result:
  - r odd and r<NR: st←(kr<<56)^o, using the old kr; then kr←kx_out.
  - r even and r<NR: st←kx_out^o; kr←kx_out.
  - r=NR: cipher←o ⊞ kr, where kr holds k9. Go OUT.
  - In all cases rnd←rnd+1.
- `<<56` is a logical 128-bit shift; the upper bits are discarded.
- **OUT:** `out_valid`=1, `cipher` held. On `out_ready`, go IDLE.
- `in_valid` outside IDLE is ignored. `dp_ack` is ignored when `dp_req`=0.
- **Reset (any state, including mid-round):** state IDLE; st, kr, cipher, rnd = 0; all outputs 0 except `in_ready`=1. Any pending round-core transaction is abandoned; the round core must tolerate `dp_req` dropping without ack.

## Timing
- Accept edge E0; WHITEN in cycle 1; `dp_req` high from cycle 2.
- `dp_req` stays high continuously across rounds. An ack in the same cycle as the request gives one round per cycle.
- Zero-wait round core: `out_valid` rises 12 cycles after E0. Each wait cycle on `dp_ack` adds 1.
- `in_ready` is low from the cycle after E0 until the cycle after the output handshake. Maximum throughput is one block per 13 cycles.
- `kx_out` is sampled on the same edge as `dp_ack` (or the WHITEN edge). There is no extra cycle for key expansion.

## Test plan
Bench model for all scenarios: round core is identity (`dp_result`=`dp_data`); key expansion is `kx_out`=`kx_in`+1 (128-bit).

- **Basic block:** msg=0, key=0, zero-wait ack, `out_ready`=1 → `out_valid` at E0+12, cipher=128'h0000000000000000_0900000000000013, `rnd` steps 1..10.
- **Lane wrap:** msg=128'h0000000000000000_FFFFFFFFFFFFFFFF, key=0 → first `dp_data`=0; the upper lane stays 0, i.e. no carry across lanes.
- **Round-core stall:** basic block with `dp_ack` delayed 3 cycles per round → identical cipher; `out_valid` at E0+42; `dp_data` stable throughout each stall.
- **Back-pressure and busy inputs:** hold `out_ready`=0 for 5 cycles → `out_valid`/`cipher` held. A second `in_valid` pulse while busy is ignored. The next block is accepted only after the output handshake.
- **Async reset mid-run:** assert `rst`=0 during round 4, asynchronously mid-cycle → outputs clear immediately, `in_ready`=1. A following block produces the basic-block cipher.
